// File: rtl/ram_arbiter.sv
// Two-requester round-robin front end for a single-port synchronous RAM.
// Accepted commands flow through three registered stages: issue (drives
// the RAM pins), capture (RAM output register is valid), and response
// (per-requester read strobe). Writes leave the pipeline after issue.
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  // ptr names the requester that wins when both are valid
  logic                  ptr;
  logic                  grant0;
  logic                  grant1;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  iss_valid;
  logic                  iss_rd;
  logic                  iss_tag;
  logic                  cap_valid;
  logic                  cap_tag;

  // Grant and command select; rst_n gating keeps ready low while in reset
  always_comb begin
    grant0    = rst_n & req0_valid & (~req1_valid | ~ptr);
    grant1    = rst_n & req1_valid & (~req0_valid |  ptr);
    accept    = grant0 | grant1;
    sel_we    = grant1 ? req1_we    : req0_we;
    sel_addr  = grant1 ? req1_addr  : req0_addr;
    sel_wdata = grant1 ? req1_wdata : req0_wdata;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Round-robin pointer: after a grant, favour the other requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= grant0;
    end
  end

  // Issue stage: registered RAM controls plus tag and read flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_rd    <= 1'b0;
      iss_tag   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
    end else begin
      iss_valid <= accept;
      iss_rd    <= accept & ~sel_we;
      ram_we    <= accept &  sel_we;
      if (accept) begin
        iss_tag  <= grant1;
        ram_addr <= sel_addr;
        ram_din  <= sel_wdata;
      end
    end
  end

  assign ram_en = iss_valid;

  // Capture stage: tracks the read whose data is on ram_dout this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_tag   <= 1'b0;
    end else begin
      cap_valid <= iss_valid & iss_rd;
      cap_tag   <= iss_tag;
    end
  end

  // Response stage: one-cycle strobe; read data holds until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= cap_valid & ~cap_tag;
      rsp1_valid <= cap_valid &  cap_tag;
      if (cap_valid && !cap_tag) rsp0_rdata <= ram_dout;
      if (cap_valid &&  cap_tag) rsp1_rdata <= ram_dout;
    end
  end

  assign busy = iss_valid | cap_valid | rsp0_valid | rsp1_valid;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM.
module tb_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_we;
  logic [2:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       rsp0_valid;
  logic [7:0] rsp0_rdata;
  logic       req1_valid, req1_ready, req1_we;
  logic [2:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       rsp1_valid;
  logic [7:0] rsp1_rdata;
  logic       ram_en, ram_we;
  logic [2:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [8];

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM with registered read data
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout      <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [2:0] a, input logic [7:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [2:0] a, input logic [7:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  task automatic idle();
    drive0(1'b0, 1'b0, 3'd0, 8'h00);
    drive1(1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  // One cycle of the mixed burst: drive, check, then advance
  task automatic burst_step(input int i,
                            input logic v0, input logic w0, input logic [2:0] a0, input logic [7:0] d0,
                            input logic v1, input logic w1, input logic [2:0] a1, input logic [7:0] d1,
                            input logic r0v, input logic [7:0] r0d,
                            input logic r1v, input logic [7:0] r1d,
                            input logic bsy, input logic en);
    drive0(v0, w0, a0, d0);
    drive1(v1, w1, a1, d1);
    #1;
    chk($sformatf("burst%0d_ready0", i), 32'(req0_ready), 32'(v0));
    chk($sformatf("burst%0d_ready1", i), 32'(req1_ready), 32'(v1));
    chk($sformatf("burst%0d_rsp0v", i), 32'(rsp0_valid), 32'(r0v));
    chk($sformatf("burst%0d_rsp1v", i), 32'(rsp1_valid), 32'(r1v));
    if (r0v) chk($sformatf("burst%0d_rsp0d", i), 32'(rsp0_rdata), 32'(r0d));
    if (r1v) chk($sformatf("burst%0d_rsp1d", i), 32'(rsp1_rdata), 32'(r1d));
    chk($sformatf("burst%0d_busy", i), 32'(busy), 32'(bsy));
    chk($sformatf("burst%0d_en", i), 32'(ram_en), 32'(en));
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    req0_valid = 1'b1;
    #12;
    // Reset state
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp0_rdata", 32'(rsp0_rdata), 32'd0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();

    // Single write from req0
    drive0(1'b1, 1'b1, 3'd0, 8'hAA);
    #1;
    chk("w_aa_ready0", 32'(req0_ready), 32'd1);
    chk("w_aa_ready1", 32'(req1_ready), 32'd0);
    tick();
    idle();
    #1;
    chk("w_aa_en", 32'(ram_en), 32'd1);
    chk("w_aa_we", 32'(ram_we), 32'd1);
    chk("w_aa_addr", 32'(ram_addr), 32'd0);
    chk("w_aa_din", 32'(ram_din), 32'hAA);
    chk("w_aa_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("w_aa_no_rsp0", 32'(rsp0_valid), 32'd0);
    end
    chk("w_aa_idle_busy", 32'(busy), 32'd0);

    // Second write, then two reads from req1
    drive0(1'b1, 1'b1, 3'd1, 8'hBB);
    tick();
    idle();
    drive1(1'b1, 1'b0, 3'd0, 8'h00);
    #1;
    chk("rd0_ready1", 32'(req1_ready), 32'd1);
    tick();
    drive1(1'b1, 1'b0, 3'd1, 8'h00);
    #1;
    chk("rd0_issue_en", 32'(ram_en), 32'd1);
    chk("rd0_issue_we", 32'(ram_we), 32'd0);
    chk("rd0_issue_addr", 32'(ram_addr), 32'd0);
    tick();
    idle();
    tick();
    #1;
    chk("rd0_rsp1v", 32'(rsp1_valid), 32'd1);
    chk("rd0_rsp1d", 32'(rsp1_rdata), 32'hAA);
    chk("rd0_rsp0v", 32'(rsp0_valid), 32'd0);
    tick();
    #1;
    chk("rd1_rsp1v", 32'(rsp1_valid), 32'd1);
    chk("rd1_rsp1d", 32'(rsp1_rdata), 32'hBB);
    tick();
    #1;
    chk("rd_end_rsp1v", 32'(rsp1_valid), 32'd0);
    chk("rd_hold_rsp1d", 32'(rsp1_rdata), 32'hBB);
    chk("rd_end_busy", 32'(busy), 32'd0);

    // Both requesters holding reads: strict alternation
    drive0(1'b1, 1'b1, 3'd2, 8'hCC);
    tick();
    idle();
    drive1(1'b1, 1'b1, 3'd3, 8'hDD);
    tick();
    drive0(1'b1, 1'b0, 3'd2, 8'h00);
    drive1(1'b1, 1'b0, 3'd3, 8'h00);
    #1;
    chk("rr_c0_ready0", 32'(req0_ready), 32'd1);
    chk("rr_c0_ready1", 32'(req1_ready), 32'd0);
    tick();
    #1;
    chk("rr_c1_ready0", 32'(req0_ready), 32'd0);
    chk("rr_c1_ready1", 32'(req1_ready), 32'd1);
    tick();
    #1;
    chk("rr_c2_ready0", 32'(req0_ready), 32'd1);
    chk("rr_c2_ready1", 32'(req1_ready), 32'd0);
    tick();
    #1;
    chk("rr_c3_ready0", 32'(req0_ready), 32'd0);
    chk("rr_c3_ready1", 32'(req1_ready), 32'd1);
    chk("rr_c3_rsp0v", 32'(rsp0_valid), 32'd1);
    chk("rr_c3_rsp0d", 32'(rsp0_rdata), 32'hCC);
    tick();
    idle();
    #1;
    chk("rr_c4_rsp1v", 32'(rsp1_valid), 32'd1);
    chk("rr_c4_rsp1d", 32'(rsp1_rdata), 32'hDD);
    chk("rr_c4_rsp0v", 32'(rsp0_valid), 32'd0);
    tick();
    #1;
    chk("rr_c5_rsp0v", 32'(rsp0_valid), 32'd1);
    chk("rr_c5_rsp0d", 32'(rsp0_rdata), 32'hCC);
    chk("rr_c5_rsp1v", 32'(rsp1_valid), 32'd0);
    tick();
    #1;
    chk("rr_c6_rsp1v", 32'(rsp1_valid), 32'd1);
    chk("rr_c6_rsp1d", 32'(rsp1_rdata), 32'hDD);
    tick();
    #1;
    chk("rr_c7_rsp0v", 32'(rsp0_valid), 32'd0);
    chk("rr_c7_rsp1v", 32'(rsp1_valid), 32'd0);

    // Write then read of the same address on the next cycle
    drive0(1'b1, 1'b1, 3'd5, 8'h55);
    #1;
    chk("b2b_ready0", 32'(req0_ready), 32'd1);
    tick();
    idle();
    drive1(1'b1, 1'b0, 3'd5, 8'h00);
    #1;
    chk("b2b_ready1", 32'(req1_ready), 32'd1);
    tick();
    idle();
    tick();
    tick();
    #1;
    chk("b2b_rsp1v", 32'(rsp1_valid), 32'd1);
    chk("b2b_rsp1d", 32'(rsp1_rdata), 32'h55);
    tick();

    // Reset while a read is in flight
    drive0(1'b1, 1'b0, 3'd2, 8'h00);
    #1;
    chk("rstmid_ready0", 32'(req0_ready), 32'd1);
    tick();
    idle();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk("rstmid_ready0_low", 32'(req0_ready), 32'd0);
    chk("rstmid_en", 32'(ram_en), 32'd0);
    chk("rstmid_we", 32'(ram_we), 32'd0);
    chk("rstmid_addr", 32'(ram_addr), 32'd0);
    chk("rstmid_din", 32'(ram_din), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_rsp0v", 32'(rsp0_valid), 32'd0);
    chk("rstmid_rsp0d", 32'(rsp0_rdata), 32'd0);
    chk("rstmid_rsp1d", 32'(rsp1_rdata), 32'd0);
    req0_valid = 1'b0;
    tick();
    #1;
    chk("rstmid_rsp0v_hold", 32'(rsp0_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      chk("postrst_rsp0v", 32'(rsp0_valid), 32'd0);
      chk("postrst_busy", 32'(busy), 32'd0);
    end
    tick();

    // Mixed burst then idle
    burst_step(0,  1'b1, 1'b1, 3'd6, 8'h11,  1'b0, 1'b0, 3'd0, 8'h00,  1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    burst_step(1,  1'b0, 1'b0, 3'd0, 8'h00,  1'b1, 1'b0, 3'd6, 8'h00,  1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    burst_step(2,  1'b1, 1'b0, 3'd0, 8'h00,  1'b0, 1'b0, 3'd0, 8'h00,  1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    burst_step(3,  1'b0, 1'b0, 3'd0, 8'h00,  1'b1, 1'b1, 3'd7, 8'h22,  1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    burst_step(4,  1'b1, 1'b0, 3'd7, 8'h00,  1'b0, 1'b0, 3'd0, 8'h00,  1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 1'b1);
    burst_step(5,  1'b0, 1'b0, 3'd0, 8'h00,  1'b1, 1'b0, 3'd3, 8'h00,  1'b1, 8'hAA, 1'b0, 8'h00, 1'b1, 1'b1);
    burst_step(6,  1'b1, 1'b1, 3'd0, 8'h33,  1'b0, 1'b0, 3'd0, 8'h00,  1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    burst_step(7,  1'b0, 1'b0, 3'd0, 8'h00,  1'b1, 1'b0, 3'd0, 8'h00,  1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b1);
    burst_step(8,  1'b0, 1'b0, 3'd0, 8'h00,  1'b0, 1'b0, 3'd0, 8'h00,  1'b0, 8'h00, 1'b1, 8'hDD, 1'b1, 1'b1);
    burst_step(9,  1'b0, 1'b0, 3'd0, 8'h00,  1'b0, 1'b0, 3'd0, 8'h00,  1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    burst_step(10, 1'b0, 1'b0, 3'd0, 8'h00,  1'b0, 1'b0, 3'd0, 8'h00,  1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0);
    burst_step(11, 1'b0, 1'b0, 3'd0, 8'h00,  1'b0, 1'b0, 3'd0, 8'h00,  1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
